// File: rtl/ex_stage_if.sv
// ID/EX-to-EX/MEM bundle for the execute stage: ID/EX operands and control in,
// EX/MEM register and the combinational stall out.
interface ex_stage_if #(
    parameter int LEN_WORD          = 32,
    parameter int LEN_REG_FILE_ADDR = 5
);
    logic                         flush;
    logic [LEN_WORD-1:0]          read_data_1;
    logic [LEN_WORD-1:0]          read_data_2;
    logic [LEN_WORD-1:0]          extended_imm;
    logic [LEN_REG_FILE_ADDR-1:0] reg_2;
    logic [LEN_REG_FILE_ADDR-1:0] reg_3;
    logic [2:0]                   alu_op;
    logic                         reg_dst;
    logic                         alu_src;
    logic                         mem_read;
    logic                         mem_write;
    logic                         reg_write;
    logic                         mem_to_reg;

    logic                         stall;
    logic [LEN_WORD-1:0]          alu_result;
    logic [LEN_WORD-1:0]          store_data;
    logic [LEN_REG_FILE_ADDR-1:0] write_reg;
    logic                         mem_read_o;
    logic                         mem_write_o;
    logic                         reg_write_o;
    logic                         mem_to_reg_o;

    modport master (
        output flush, read_data_1, read_data_2, extended_imm, reg_2, reg_3, alu_op,
               reg_dst, alu_src, mem_read, mem_write, reg_write, mem_to_reg,
        input  stall, alu_result, store_data, write_reg,
               mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o
    );

    modport slave (
        input  flush, read_data_1, read_data_2, extended_imm, reg_2, reg_3, alu_op,
               reg_dst, alu_src, mem_read, mem_write, reg_write, mem_to_reg,
        output stall, alu_result, store_data, write_reg,
               mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, EX/MEM pipeline register and, when EX_MUL_EN is
// defined, an iterative shift-add multiplier that stalls upstream while busy.
module ex_stage #(
    parameter int LEN_WORD          = 32,
    parameter int LEN_REG_FILE_ADDR = 5
) (
    input logic       clk,
    input logic       reset,
    ex_stage_if.slave bus
);
    localparam int LEN_CNT = $clog2(LEN_WORD + 1);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_SLT = 3'b100,
        OP_NOR = 3'b101,
        OP_MUL = 3'b110,
        OP_XOR = 3'b111
    } alu_op_e;

    alu_op_e                      op;
    logic [LEN_WORD-1:0]          op_a;
    logic [LEN_WORD-1:0]          op_b;
    logic [LEN_WORD-1:0]          alu_value;
    logic [LEN_WORD-1:0]          mul_result;
    logic [LEN_REG_FILE_ADDR-1:0] dst_reg;
    logic                         stall;

    logic [LEN_WORD-1:0]          alu_result_q;
    logic [LEN_WORD-1:0]          store_data_q;
    logic [LEN_REG_FILE_ADDR-1:0] write_reg_q;
    logic                         mem_read_q;
    logic                         mem_write_q;
    logic                         reg_write_q;
    logic                         mem_to_reg_q;

    assign op      = alu_op_e'(bus.alu_op);
    assign op_a    = bus.read_data_1;
    assign op_b    = bus.alu_src ? bus.extended_imm : bus.read_data_2;
    assign dst_reg = bus.reg_dst ? bus.reg_3 : bus.reg_2;

`ifdef EX_MUL_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e              state;
    state_e              state_nxt;
    logic [LEN_CNT-1:0]  cnt;
    logic [LEN_WORD-1:0] mcand;
    logic [LEN_WORD-1:0] mplier;
    logic [LEN_WORD-1:0] prod;
    logic                mul_start;
    logic                mul_step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (op == OP_MUL) state_nxt = BUSY;
            BUSY:    if (cnt == LEN_CNT'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) begin
            state_nxt = IDLE;
        end
    end

    // Reset gates stall too, so a held MUL on the inputs cannot raise it during reset.
    always_comb begin
        stall     = 1'b0;
        mul_start = 1'b0;
        mul_step  = 1'b0;
        if (!bus.flush && !reset) begin
            case (state)
                IDLE: begin
                    if (op == OP_MUL) begin
                        stall     = 1'b1;
                        mul_start = 1'b1;
                    end
                end
                BUSY: begin
                    stall    = 1'b1;
                    mul_step = 1'b1;
                end
                default: stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
        end else if (mul_start) begin
            cnt    <= LEN_CNT'(LEN_WORD);
            mcand  <= op_a;
            mplier <= op_b;
            prod   <= '0;
        end else if (mul_step) begin
            if (mplier[0]) begin
                prod <= prod + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - LEN_CNT'(1);
        end
    end

    assign mul_result = prod;
`else
    assign stall      = 1'b0;
    assign mul_result = '0;
`endif

    always_comb begin
        alu_value = '0;
        case (op)
            OP_ADD: alu_value = op_a + op_b;
            OP_SUB: alu_value = op_a - op_b;
            OP_AND: alu_value = op_a & op_b;
            OP_OR:  alu_value = op_a | op_b;
            OP_SLT: alu_value = {{(LEN_WORD-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_NOR: alu_value = ~(op_a | op_b);
            OP_MUL: alu_value = mul_result;
            OP_XOR: alu_value = op_a ^ op_b;
        endcase
    end

    // Flush and stall both load a bubble; only an unstalled, unflushed cycle commits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_result_q <= '0;
            store_data_q <= '0;
            write_reg_q  <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else if (stall || bus.flush) begin
            alu_result_q <= '0;
            store_data_q <= '0;
            write_reg_q  <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            alu_result_q <= alu_value;
            store_data_q <= bus.read_data_2;
            write_reg_q  <= dst_reg;
            mem_read_q   <= bus.mem_read;
            mem_write_q  <= bus.mem_write;
            reg_write_q  <= bus.reg_write;
            mem_to_reg_q <= bus.mem_to_reg;
        end
    end

    assign bus.stall        = stall;
    assign bus.alu_result   = alu_result_q;
    assign bus.store_data   = store_data_q;
    assign bus.write_reg    = write_reg_q;
    assign bus.mem_read_o   = mem_read_q;
    assign bus.mem_write_o  = mem_write_q;
    assign bus.reg_write_o  = reg_write_q;
    assign bus.mem_to_reg_o = mem_to_reg_q;
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed literal cases plus randomized instruction
// streams compared each cycle against a transaction-level model of the stage.
module tb_ex_stage;
    localparam int W  = 32;
    localparam int RA = 5;
`ifdef EX_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_stage_if #(.LEN_WORD(W), .LEN_REG_FILE_ADDR(RA)) bus ();
    ex_stage #(.LEN_WORD(W), .LEN_REG_FILE_ADDR(RA)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [W-1:0]  imm;
        logic [RA-1:0] r2;
        logic [RA-1:0] r3;
        logic [2:0]    op;
        logic          dst;
        logic          src;
        logic          mr;
        logic          mw;
        logic          rw;
        logic          m2r;
    } instr_t;

    typedef struct packed {
        logic [W-1:0]  res;
        logic [W-1:0]  sd;
        logic [RA-1:0] wr;
        logic          mr;
        logic          mw;
        logic          rw;
        logic          m2r;
    } out_t;

    int n_total = 0;
    int n_pass  = 0;

    // Model: expected EX/MEM contents plus a countdown of remaining multiplier stall cycles.
    out_t         exp_q      = '0;
    int           stall_left = 0;
    bit           pending    = 1'b0;
    logic [W-1:0] mul_prod   = '0;
    bit           last_stall = 1'b0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, got, want);
    endtask

    function automatic logic [W-1:0] opb(input instr_t i);
        return i.src ? i.imm : i.b;
    endfunction

    function automatic logic [W-1:0] alu_ref(input instr_t i, input logic [W-1:0] mulv);
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = i.a;
        b = opb(i);
        case (i.op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return ($signed(a) < $signed(b)) ? 1 : 0;
            3'd5:    return ~(a | b);
            3'd6:    return mulv;
            default: return a ^ b;
        endcase
    endfunction

    function automatic out_t capture(input instr_t i, input logic [W-1:0] mulv);
        out_t o;
        o.res = alu_ref(i, mulv);
        o.sd  = i.b;
        o.wr  = i.dst ? i.r3 : i.r2;
        o.mr  = i.mr;
        o.mw  = i.mw;
        o.rw  = i.rw;
        o.m2r = i.m2r;
        return o;
    endfunction

    function automatic bit model_stall(input instr_t i, input bit fl);
        if (fl) return 1'b0;
        if (stall_left > 0) return 1'b1;
        if (pending) return 1'b0;
        if (MUL_EN && i.op == 3'd6) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge(input instr_t i, input bit fl);
        if (fl) begin
            stall_left = 0;
            pending    = 1'b0;
            exp_q      = '0;
        end else if (stall_left > 0) begin
            stall_left--;
            exp_q = '0;
        end else if (pending) begin
            pending = 1'b0;
            exp_q   = capture(i, mul_prod);
        end else if (MUL_EN && i.op == 3'd6) begin
            stall_left = W;
            pending    = 1'b1;
            mul_prod   = i.a * opb(i);
            exp_q      = '0;
        end else begin
            exp_q = capture(i, '0);
        end
    endtask

    function automatic out_t get_out();
        out_t o;
        o.res = bus.alu_result;
        o.sd  = bus.store_data;
        o.wr  = bus.write_reg;
        o.mr  = bus.mem_read_o;
        o.mw  = bus.mem_write_o;
        o.rw  = bus.reg_write_o;
        o.m2r = bus.mem_to_reg_o;
        return o;
    endfunction

    task automatic drive(input instr_t i, input bit fl);
        bus.flush        = fl;
        bus.read_data_1  = i.a;
        bus.read_data_2  = i.b;
        bus.extended_imm = i.imm;
        bus.reg_2        = i.r2;
        bus.reg_3        = i.r3;
        bus.alu_op       = i.op;
        bus.reg_dst      = i.dst;
        bus.alu_src      = i.src;
        bus.mem_read     = i.mr;
        bus.mem_write    = i.mw;
        bus.reg_write    = i.rw;
        bus.mem_to_reg   = i.m2r;
    endtask

    task automatic cycle(input instr_t i, input bit fl);
        bit es;
        @(negedge clk);
        drive(i, fl);
        #1;
        es = model_stall(i, fl);
        check("stall", bus.stall, es);
        last_stall = es;
        @(posedge clk);
        model_edge(i, fl);
        #1;
        check("exmem", get_out(), exp_q);
    endtask

    task automatic issue(input instr_t i, output int stalls);
        int guard;
        guard  = 0;
        stalls = 0;
        do begin
            cycle(i, 1'b0);
            if (last_stall) stalls++;
            guard++;
        end while (last_stall && guard < 100);
        if (last_stall) begin
            n_total++;
            $display("FAIL issue_timeout: stall still high after %0d cycles, want low", guard);
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before the next edge.
    task automatic reset_mid();
        instr_t z;
        z = '0;
        #3;
        reset = 1'b1;
        #1;
        check("rst_async_out", get_out(), '0);
        check("rst_async_stall", bus.stall, 1'b0);
        exp_q      = '0;
        stall_left = 0;
        pending    = 1'b0;
        drive(z, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic instr_t mk(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] imm, input logic src, input logic dst,
                                  input logic [RA-1:0] r3, input logic rw);
        instr_t i;
        i     = '0;
        i.op  = op;
        i.a   = a;
        i.b   = b;
        i.imm = imm;
        i.src = src;
        i.dst = dst;
        i.r3  = r3;
        i.rw  = rw;
        return i;
    endfunction

    function automatic logic [W-1:0] rand_word();
        case ($urandom_range(0, 3))
            0: return W'($urandom_range(0, 15));
            1: begin
                case ($urandom_range(0, 3))
                    0:       return 32'h0000_0000;
                    1:       return 32'hFFFF_FFFF;
                    2:       return 32'h7FFF_FFFF;
                    default: return 32'h8000_0000;
                endcase
            end
            default: return $urandom();
        endcase
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.a   = rand_word();
        i.b   = rand_word();
        i.imm = rand_word();
        i.r2  = RA'($urandom_range(0, 31));
        i.r3  = RA'($urandom_range(0, 31));
        if ($urandom_range(0, 7) == 0) i.op = 3'd6;
        else begin
            i.op = 3'($urandom_range(0, 6));
            if (i.op == 3'd6) i.op = 3'd7;
        end
        i.dst = 1'($urandom_range(0, 1));
        i.src = 1'($urandom_range(0, 1));
        i.mr  = 1'($urandom_range(0, 1));
        i.mw  = 1'($urandom_range(0, 1));
        i.rw  = 1'($urandom_range(0, 1));
        i.m2r = 1'($urandom_range(0, 1));
        return i;
    endfunction

    initial begin
        instr_t z;
        instr_t cur;
        instr_t m;
        int     s;
        bit     seen42;
        bit     fl;
        z     = '0;
        reset = 1'b1;
        drive(z, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", get_out(), '0);
        check("reset_stall", bus.stall, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        issue(mk(3'd0, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 5'd9, 1'b1), s);
        check("add_res", bus.alu_result, 32'd12);
        check("add_wr", bus.write_reg, 5'd9);
        check("add_rw", bus.reg_write_o, 1'b1);

        issue(mk(3'd1, 32'd3, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd0, 1'b1), s);
        check("sub_imm_res", bus.alu_result, 32'd4);
        issue(mk(3'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1), s);
        check("slt_res", bus.alu_result, 32'd1);
        reset_mid();

`ifdef EX_MUL_EN
        issue(mk(3'd6, 32'd6, 32'd7, 32'd0, 1'b0, 1'b1, 5'd5, 1'b1), s);
        check("mul_stall_cycles", s, 33);
        check("mul_res", bus.alu_result, 32'd42);
        check("mul_rw", bus.reg_write_o, 1'b1);

        issue(mk(3'd6, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1), s);
        check("mul_wrap_res", bus.alu_result, 32'hFFFF_FFFE);
        issue(mk(3'd6, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1), s);
        check("mul_b2b_res", bus.alu_result, 32'd12);
        check("mul_b2b_stall", s, 33);

        m = mk(3'd6, 32'd6, 32'd7, 32'd0, 1'b0, 1'b1, 5'd5, 1'b1);
        repeat (11) cycle(m, 1'b0);
        cycle(m, 1'b1);
        check("flush_res", bus.alu_result, 32'd0);
        seen42 = 1'b0;
        repeat (40) begin
            cycle(z, 1'b0);
            if (bus.alu_result == 32'd42) seen42 = 1'b1;
        end
        check("flush_no_result", seen42, 1'b0);

        repeat (11) cycle(m, 1'b0);
        reset_mid();
        seen42 = 1'b0;
        repeat (40) begin
            cycle(z, 1'b0);
            if (bus.alu_result == 32'd42) seen42 = 1'b1;
        end
        check("reset_no_result", seen42, 1'b0);
`else
        m     = mk(3'd6, 32'd6, 32'd7, 32'd0, 1'b0, 1'b1, 5'd5, 1'b1);
        m.m2r = 1'b1;
        issue(m, s);
        check("mul_off_stall", s, 0);
        check("mul_off_res", bus.alu_result, 32'd0);
        check("mul_off_rw", bus.reg_write_o, 1'b1);
        check("mul_off_wr", bus.write_reg, 5'd5);
        check("mul_off_m2r", bus.mem_to_reg_o, 1'b1);
`endif

        cur        = '0;
        last_stall = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (!last_stall) cur = rand_instr();
            fl = ($urandom_range(0, 29) == 0);
            cycle(cur, fl);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
